// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a single-port data memory (negedge write,
// combinational read). Partial writes are done as read-modify-write.
module dm_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [11:2] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [11:2] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [11:2] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy,
    output logic        grant_id
);

    // state | meaning
    // IDLE  | waiting for a request, arbitrates on any req
    // XFER  | memory access with latched address (read / full write / RMW read)
    // WR    | second half of a partial write, merged word written
    // ACK   | one-cycle ack to the granted master
    typedef enum logic [1:0] {IDLE, XFER, WR, ACK} state_t;

    state_t      state_q;
    logic        gid_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [11:2] mem_addr_q;
    logic        mem_we_q;
    logic [31:0] mem_din_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_ack_q;
    logic        m1_ack_q;

    logic        win_d;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [11:2] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] merged_d;

    always_comb begin
        win_d = 1'b0;
        if (m0_req && m1_req) begin
            win_d = RR_EN ? ~gid_q : 1'b0;
        end else begin
            win_d = m1_req;
        end
        sel_we    = win_d ? m1_we    : m0_we;
        sel_be    = win_d ? m1_be    : m0_be;
        sel_addr  = win_d ? m1_addr  : m0_addr;
        sel_wdata = win_d ? m1_wdata : m0_wdata;
        merged_d  = '0;
        for (int i = 0; i < 4; i++) begin
            merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dout[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gid_q      <= 1'b1;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= 32'h0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gid_q      <= win_d;
                        we_q       <= sel_we;
                        be_q       <= sel_be;
                        wdata_q    <= sel_wdata;
                        mem_addr_q <= sel_addr;
                        mem_din_q  <= sel_wdata;
                        // full writes go out in XFER, so the strobe is set on grant
                        mem_we_q   <= sel_we && (sel_be == 4'hF);
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (we_q && (be_q != 4'h0) && (be_q != 4'hF)) begin
                        mem_din_q <= merged_d;
                        mem_we_q  <= 1'b1;
                        state_q   <= WR;
                    end else begin
                        if (!we_q) begin
                            if (gid_q) m1_rdata_q <= mem_dout;
                            else       m0_rdata_q <= mem_dout;
                        end
                        m0_ack_q <= ~gid_q;
                        m1_ack_q <= gid_q;
                        state_q  <= ACK;
                    end
                end
                WR: begin
                    m0_ack_q <= ~gid_q;
                    m1_ack_q <= gid_q;
                    state_q  <= ACK;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving before the negedge suppresses the pending write.
    assign mem_we   = mem_we_q & rst_n;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: round-robin instance with a memory model,
// plus a fixed-priority instance sharing the same requester inputs.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [11:2] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic [31:0] m0_rdata_a, m1_rdata_a, m0_rdata_b, m1_rdata_b;
    logic        m0_ack_a, m1_ack_a, m0_ack_b, m1_ack_b;
    logic [11:2] mem_addr_a, mem_addr_b;
    logic        mem_we_a, mem_we_b;
    logic [31:0] mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;
    logic        busy_a, busy_b, gid_a, gid_b;

    logic [31:0] mema [0:1023];
    logic [31:0] memb [0:1023];
    int          wr_cnt_a = 0;
    logic [31:0] last_din_a = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_dout_a = mema[mem_addr_a];
    assign mem_dout_b = memb[mem_addr_b];

    always @(negedge clk) begin
        if (mem_we_a) begin
            mema[mem_addr_a] <= mem_din_a;
            wr_cnt_a         <= wr_cnt_a + 1;
            last_din_a       <= mem_din_a;
        end
        if (mem_we_b) memb[mem_addr_b] <= mem_din_b;
    end

    dm_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_a), .m0_ack(m0_ack_a),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_a), .m1_ack(m1_ack_a),
        .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_din(mem_din_a),
        .mem_dout(mem_dout_a), .busy(busy_a), .grant_id(gid_a)
    );

    dm_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_b), .m0_ack(m0_ack_b),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_b), .m1_ack(m1_ack_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_din(mem_din_b),
        .mem_dout(mem_dout_b), .busy(busy_b), .grant_id(gid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on the RR instance; lat is the posedge (counted from
    // the sampling edge) at which the requester sees ack, nwr the write strobes.
    task automatic xact(input bit m, input bit we, input logic [3:0] be,
                        input logic [11:2] addr, input logic [31:0] wd,
                        output int lat, output int nwr);
        int n;
        int w0;
        w0 = wr_cnt_a;
        if (!m) begin
            m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end
        tick;
        chk("busy_after_grant", busy_a, 1);
        chk("grant_id", gid_a, m);
        if (!m) begin
            m0_we = ~we; m0_be = ~be; m0_addr = ~addr; m0_wdata = ~wd;
        end else begin
            m1_we = ~we; m1_be = ~be; m1_addr = ~addr; m1_wdata = ~wd;
        end
        n = 0;
        do begin
            tick;
            n++;
        end while (!(m ? m1_ack_a : m0_ack_a) && n < 10);
        lat = n + 1;
        chk("other_ack_low", m ? m0_ack_a : m1_ack_a, 0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick;
        chk("ack_one_cycle", m0_ack_a | m1_ack_a, 0);
        chk("idle_after_ack", busy_a, 0);
        chk("we_low_idle", mem_we_a, 0);
        nwr = wr_cnt_a - w0;
    endtask

    initial begin
        int lat, nwr, w0;
        int seq_a[$];
        int nb0, nb1, overlap, consec;
        logic pa0, pa1;

        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = '0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = '0; m1_wdata = 0;
        tick;
        tick;
        chk("rst_mem_we", mem_we_a, 0);
        chk("rst_acks", {m0_ack_a, m1_ack_a}, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_grant_id", gid_a, 1);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_din", mem_din_a, 0);
        chk("rst_m0_rdata", m0_rdata_a, 0);
        chk("rst_m1_rdata", m1_rdata_a, 0);
        chk("rst_fp_busy", busy_b, 0);
        chk("rst_fp_grant_id", gid_b, 1);
        rst_n = 1'b1;
        tick;

        // full write then read of 0xDEADBEEF
        xact(0, 1, 4'hF, 10'h010, 32'hDEADBEEF, lat, nwr);
        chk("fullwr_lat", lat, 2);
        chk("fullwr_nwr", nwr, 1);
        chk("fullwr_mem", mema[10'h010], 32'hDEADBEEF);
        xact(0, 0, 4'hF, 10'h010, 32'h0, lat, nwr);
        chk("rd_lat", lat, 2);
        chk("rd_nwr", nwr, 0);
        chk("rd_m0_rdata", m0_rdata_a, 32'hDEADBEEF);
        chk("rd_m1_rdata_unchanged", m1_rdata_a, 0);

        // partial write by m1 over 0xAABBCCDD
        xact(1, 1, 4'hF, 10'h020, 32'hAABBCCDD, lat, nwr);
        chk("m1_fullwr_nwr", nwr, 1);
        xact(1, 1, 4'b0011, 10'h020, 32'h00001234, lat, nwr);
        chk("pwr_lat", lat, 3);
        chk("pwr_nwr", nwr, 1);
        chk("pwr_din", last_din_a, 32'hAABB1234);
        chk("pwr_mem", mema[10'h020], 32'hAABB1234);
        chk("pwr_m0_rdata_held", m0_rdata_a, 32'hDEADBEEF);

        // be=0 write is a no-op
        xact(0, 1, 4'hF, 10'h030, 32'h11111111, lat, nwr);
        xact(0, 1, 4'h0, 10'h030, 32'h22222222, lat, nwr);
        chk("be0_lat", lat, 2);
        chk("be0_nwr", nwr, 0);
        xact(0, 0, 4'hF, 10'h030, 32'h0, lat, nwr);
        chk("be0_readback", m0_rdata_a, 32'h11111111);

        // reset while in WR of a partial write
        xact(1, 1, 4'hF, 10'h040, 32'hCAFEF00D, lat, nwr);
        w0 = wr_cnt_a;
        m1_we = 1; m1_be = 4'b1100; m1_addr = 10'h040; m1_wdata = 32'h12345678; m1_req = 1;
        tick;
        tick;
        chk("wr_state_we", mem_we_a, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_blocks_we", mem_we_a, 0);
        tick;
        chk("rst_wr_idle", busy_a, 0);
        chk("rst_wr_noack", {m0_ack_a, m1_ack_a}, 0);
        m1_req = 1'b0;
        rst_n = 1'b1;
        tick;
        chk("rst_wr_noack2", {m0_ack_a, m1_ack_a, mem_we_a}, 0);
        tick;
        chk("rst_wr_nwr", wr_cnt_a - w0, 0);
        chk("rst_wr_mem_old", mema[10'h040], 32'hCAFEF00D);
        chk("rst_wr_gid", gid_a, 1);

        // simultaneous requests from reset, both held
        rst_n = 1'b0;
        m0_we = 0; m0_be = 4'hF; m0_addr = 10'h010;
        m1_we = 0; m1_be = 4'hF; m1_addr = 10'h020;
        m0_req = 1; m1_req = 1;
        tick;
        tick;
        rst_n = 1'b1;
        nb0 = 0; nb1 = 0; overlap = 0; consec = 0; pa0 = 0; pa1 = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (m0_ack_a && m1_ack_a) overlap++;
            if ((m0_ack_a && pa0) || (m1_ack_a && pa1)) consec++;
            pa0 = m0_ack_a;
            pa1 = m1_ack_a;
            if (m0_ack_a) seq_a.push_back(0);
            if (m1_ack_a) seq_a.push_back(1);
            if (m0_ack_b) nb0++;
            if (m1_ack_b) nb1++;
        end
        m0_req = 0;
        m1_req = 0;
        chk("rr_count", seq_a.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order_%0d", i), (seq_a.size() > i) ? seq_a[i] : -1, i % 2);
        end
        chk("rr_overlap", overlap, 0);
        chk("rr_ack_one_cycle", consec, 0);
        chk("rr_m0_rdata", m0_rdata_a, 32'hDEADBEEF);
        chk("rr_m1_rdata", m1_rdata_a, 32'hAABB1234);
        chk("fp_m0_count", nb0 >= 4, 1);
        chk("fp_m1_none", nb1, 0);
        chk("fp_m0_rdata", m0_rdata_b, 32'hDEADBEEF);
        chk("fp_m1_rdata", m1_rdata_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with m0 always winning.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports m0_req and m1_req, input, 1 bit each: access request, held high until ack is sampled.
REQ-005 The block SHALL have ports m0_we and m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports m0_be and m1_be, input, 4 bits each: byte enables; bit i covers data[8i+7:8i].
REQ-007 The block SHALL have ports m0_addr and m1_addr, input, [11:2]: word address.
REQ-008 The block SHALL have ports m0_wdata and m1_wdata, input, 32 bits each: write data.
REQ-009 The block SHALL have ports m0_rdata and m1_rdata, output, 32 bits each: read data, valid while the matching ack is high.
REQ-010 The block SHALL have ports m0_ack and m1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-011 The block SHALL have port mem_addr, output, [11:2]: address to the data memory.
REQ-012 The block SHALL have port mem_we, output, 1 bit: memory write enable; the memory writes on negedge clk.
REQ-013 The block SHALL have port mem_din, output, 32 bits: write data to the memory.
REQ-014 The block SHALL have port mem_dout, input, 32 bits: combinational read data from the memory.
REQ-015 The block SHALL have port busy, output, 1 bit: 1 whenever state != IDLE.
REQ-016 The block SHALL have port grant_id, output, 1 bit: index of the currently or last granted requester.

Function
REQ-017 The block SHALL implement the states IDLE, XFER, WR and ACK.
REQ-018 In IDLE, on a posedge with any req=1, the block SHALL select a winner, latch its we/be/addr/wdata, update grant_id, and go to XFER.
REQ-019 Requester inputs changing after the grant SHALL NOT affect the transaction in flight.
REQ-020 With RR_EN=1 and both req high, the block SHALL grant the requester that is not the last one granted.
REQ-021 With RR_EN=0, m0 SHALL always win a tie.
REQ-022 A single requester SHALL be granted regardless of arbitration history.
REQ-023 In XFER, WR and ACK, mem_addr SHALL equal the latched address.
REQ-024 In XFER, a read (we=0) SHALL capture mem_dout into the read register and go to ACK, with mem_we=0.
REQ-025 In XFER, a full write (be=4'hF) SHALL drive mem_we=1 with mem_din = latched wdata, then go to ACK.
REQ-026 In XFER, a partial write (be not 0 and not F) SHALL drive mem_we=0, capture mem_dout, and go to WR.
REQ-027 In WR, the block SHALL drive mem_we=1 with mem_din built per byte (wdata byte where be=1, captured byte where be=0), then go to ACK.
REQ-028 A write with be=4'h0 SHALL be a no-op: mem_we stays 0, and it completes as a read does without changing memory; m*_rdata is don't-care.
REQ-029 In ACK, the granted requester's ack SHALL be 1 for exactly one cycle while the other ack stays 0; the state SHALL then return to IDLE.
REQ-030 The block SHALL ignore req in XFER, WR and ACK.
REQ-031 A req still high in the IDLE cycle after ACK SHALL start a new transaction.
REQ-032 Latency from the posedge at which req is sampled to ack high SHALL be 2 cycles for reads, full writes and be=0 writes, and 3 cycles for partial writes.
REQ-033 m*_rdata SHALL hold the last captured value between transactions.
REQ-034 The ungranted requester's rdata SHALL be unchanged.
REQ-035 mem_we SHALL be 0 in IDLE and ACK.
REQ-036 mem_we SHALL be high for at most one cycle per transaction.

Reset
REQ-037 While rst_n=0 at a posedge, the next state SHALL be IDLE.
REQ-038 Reset SHALL set mem_we=0, both acks 0, busy=0, grant_id=1 (so m0 wins the first tie), and mem_addr=0, mem_din=0, m0_rdata=0 and m1_rdata=0.
REQ-039 Reset asserted mid-transaction SHALL abort it with no ack.
REQ-040 If reset lands in XFER or WR, a write SHALL occur only if mem_we was already high during that cycle; no further write SHALL follow.

Verification
REQ-041 Read, m0, addr 0x010, mem word 0xDEADBEEF: m0_ack high 2 cycles after req is sampled, m0_rdata = 0xDEADBEEF, mem_we never 1.
REQ-042 Partial write, m1, be=4'b0011, wdata 0x00001234, old word 0xAABBCCDD: exactly one mem_we cycle with mem_din = 0xAABB1234; m1_ack at cycle 3.
REQ-043 Simultaneous req from reset with RR_EN=1, both held: grant order m0, m1, m0, m1; each ack is one cycle and the acks never overlap.
REQ-044 Same as REQ-043 with RR_EN=0: m0 is granted on every transaction while it keeps requesting; m1 gets no ack.
REQ-045 rst_n=0 during WR of a partial write: the next cycle is IDLE, no ack, and mem_we=0 from that point; memory holds the old word.
REQ-046 m0 write with be=0 to a word holding 0x11111111: ack at cycle 2, mem_we stays 0, and a following read returns 0x11111111.
